// File: rtl/rgb_led_pwm_pkg.sv
// Shared definitions for the RGB LED PWM driver.
//   DutyWDefault : default duty / step-counter width
//   NumColours   : number of LED channels
//   colour_e     : channel index (Red, Green, Blue)
//   gamma()      : g = (d * (d + 1)) >> w, used only when RGB_LED_PWM_GAMMA_EN is defined
package rgb_led_pwm_pkg;

  localparam int unsigned DutyWDefault = 8;
  localparam int unsigned NumColours   = 3;

  typedef enum logic [1:0] {
    Red   = 2'd0,
    Green = 2'd1,
    Blue  = 2'd2
  } colour_e;

  // Supports duty widths up to 16 bits; g(0) = 0 and g(2**w - 1) = 2**w - 1.
  function automatic logic [15:0] gamma(input logic [15:0] d, input int unsigned w);
    return 16'(({17'b0, d} * ({17'b0, d} + 33'd1)) >> w);
  endfunction

endpackage

// File: rtl/rgb_led_pwm_channel.sv
// One PWM colour channel: active duty register, optional gamma, compare and registered
// active-low LED output.
// Optional feature macro: RGB_LED_PWM_GAMMA_EN (gamma-correct the duty on load).
// Ports:
//   clk_i    : system clock
//   rst_i    : synchronous active-high reset
//   enable_i : PWM running; 0 forces the LED off
//   load_i   : copy duty_i into the active duty register
//   duty_i   : pending duty for this colour
//   count_i  : current PWM step counter
//   led_n_o  : active-low LED drive, one cycle behind count_i
module rgb_led_pwm_channel
  import rgb_led_pwm_pkg::*;
#(
  parameter int unsigned DutyW = DutyWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [DutyW-1:0] duty_i,
  input  logic [DutyW-1:0] count_i,
  output logic             led_n_o
);

  logic [DutyW-1:0] active_q, active_d;
  logic [DutyW-1:0] eff_duty;
  logic             led_n_q, led_n_d;

`ifdef RGB_LED_PWM_GAMMA_EN
  assign eff_duty = DutyW'(gamma(16'(duty_i), DutyW));
`else
  assign eff_duty = duty_i;
`endif

  always_comb begin
    active_d = active_q;
    if (load_i) begin
      active_d = eff_duty;
    end
    // The counter never exceeds MAX-1, so a duty of MAX is on for the whole period.
    led_n_d = ~(enable_i & (count_i < active_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= '0;
      led_n_q  <= 1'b1;
    end else begin
      active_q <= active_d;
      led_n_q  <= led_n_d;
    end
  end

  assign led_n_o = led_n_q;

endmodule

// File: rtl/rgb_led_pwm.sv
// Active-low RGB LED PWM driver with double-buffered duty updates.
// Optional feature macro: RGB_LED_PWM_GAMMA_EN (gamma-corrected duties, see channel).
// Ports:
//   clock, reset          : system clock, synchronous active-high reset
//   enable                : 1 = PWM running, 0 = LEDs off and counters held at 0
//   duty_red/green/blue   : requested duty triple
//   duty_valid/duty_ready : handshake for the duty triple
//   period_start          : one-cycle pulse in the first cycle of each PWM period
//   led_red/green/blue_n  : active-low LED outputs
module rgb_led_pwm
  import rgb_led_pwm_pkg::*;
#(
  parameter int unsigned DUTY_W   = DutyWDefault,
  parameter int unsigned PRESCALE = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_red,
  input  logic [DUTY_W-1:0] duty_green,
  input  logic [DUTY_W-1:0] duty_blue,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              period_start,
  output logic              led_red_n,
  output logic              led_green_n,
  output logic              led_blue_n
);

  localparam int unsigned       PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0]   PreLast = PreW'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0] CntLast = DUTY_W'((2 ** DUTY_W) - 2);

  logic [PreW-1:0]                    pre_q, pre_d;
  logic [DUTY_W-1:0]                  cnt_q, cnt_d;
  logic                               run_q, run_d;
  logic                               pend_full_q, pend_full_d;
  logic [NumColours-1:0][DUTY_W-1:0]  pend_q, pend_d;
  logic [NumColours-1:0][DUTY_W-1:0]  duty_in;
  logic                               period_start_q, period_start_d;
  logic [NumColours-1:0]              led_n;
  logic                               tick, boundary, accept, load;

  assign duty_in[Red]   = duty_red;
  assign duty_in[Green] = duty_green;
  assign duty_in[Blue]  = duty_blue;

  // run_q gates counting so the first enabled cycle only arms the restart; the counter
  // starts moving in the cycle that period_start marks as step 0.
  assign tick     = enable & run_q & (pre_q == PreLast);
  assign boundary = tick & (cnt_q == CntLast);
  assign accept   = duty_valid & ~pend_full_q;
  // Disabling flushes the pending triple so the handshake never stalls while idle.
  assign load     = pend_full_q & (boundary | ~enable);

  always_comb begin
    pre_d          = pre_q;
    cnt_d          = cnt_q;
    run_d          = enable;
    pend_d         = pend_q;
    pend_full_d    = pend_full_q;
    period_start_d = enable & (boundary | ~run_q);

    if (!enable) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (run_q) begin
      if (tick) begin
        pre_d = '0;
        cnt_d = boundary ? '0 : cnt_q + 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // accept and load are exclusive: accept needs an empty buffer, load a full one.
    if (accept) begin
      pend_d      = duty_in;
      pend_full_d = 1'b1;
    end else if (load) begin
      pend_full_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      run_q          <= 1'b0;
      pend_q         <= '0;
      pend_full_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      run_q          <= run_d;
      pend_q         <= pend_d;
      pend_full_q    <= pend_full_d;
      period_start_q <= period_start_d;
    end
  end

  for (genvar c = 0; c < NumColours; c++) begin : g_channel
    rgb_led_pwm_channel #(
      .DutyW (DUTY_W)
    ) u_channel (
      .clk_i    (clock),
      .rst_i    (reset),
      .enable_i (enable),
      .load_i   (load),
      .duty_i   (pend_q[c]),
      .count_i  (cnt_q),
      .led_n_o  (led_n[c])
    );
  end

  assign duty_ready   = ~pend_full_q;
  assign period_start = period_start_q;
  assign led_red_n    = led_n[Red];
  assign led_green_n  = led_n[Green];
  assign led_blue_n   = led_n[Blue];

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed bench for rgb_led_pwm: one instance with PRESCALE=1, one with PRESCALE=3,
// both DUTY_W=4. Expected values are queued when stimulus is applied and compared
// when the corresponding DUT output is observed.
module tb_rgb_led_pwm;

  localparam int unsigned W = 4;

  logic         clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, enable, duty_valid;
  logic [W-1:0] duty_red, duty_green, duty_blue;
  logic         duty_ready, period_start, led_red_n, led_green_n, led_blue_n;

  logic         reset3, enable3, duty_valid3;
  logic [W-1:0] duty_red3, duty_green3, duty_blue3;
  logic         duty_ready3, period_start3, led_red_n3, led_green_n3, led_blue_n3;

  rgb_led_pwm #(.DUTY_W(W), .PRESCALE(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .duty_red     (duty_red),
    .duty_green   (duty_green),
    .duty_blue    (duty_blue),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .period_start (period_start),
    .led_red_n    (led_red_n),
    .led_green_n  (led_green_n),
    .led_blue_n   (led_blue_n)
  );

  rgb_led_pwm #(.DUTY_W(W), .PRESCALE(3)) dut3 (
    .clock        (clock),
    .reset        (reset3),
    .enable       (enable3),
    .duty_red     (duty_red3),
    .duty_green   (duty_green3),
    .duty_blue    (duty_blue3),
    .duty_valid   (duty_valid3),
    .duty_ready   (duty_ready3),
    .period_start (period_start3),
    .led_red_n    (led_red_n3),
    .led_green_n  (led_green_n3),
    .led_blue_n   (led_blue_n3)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Effective on-steps for a requested duty.
  function automatic int eff(int d);
`ifdef RGB_LED_PWM_GAMMA_EN
    return (d * (d + 1)) >> W;
`else
    return d;
`endif
  endfunction

  task automatic expect_val(string tag, int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(integer obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0d expected nothing queued", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Cycles until the next period_start pulse; -1 if the limit expires.
  task automatic wait_ps(input bit sel, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((sel ? period_start3 : period_start) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  // Counts lit cycles per colour over len cycles; drops duty_valid after the first edge.
  task automatic measure(input bit sel, input int len, output int r, output int g,
                         output int b, output logic rdy1);
    r = 0;
    g = 0;
    b = 0;
    rdy1 = 1'b0;
    for (int i = 0; i < len; i++) begin
      tick();
      if (i == 0) begin
        rdy1        = sel ? duty_ready3 : duty_ready;
        duty_valid  = 1'b0;
        duty_valid3 = 1'b0;
      end
      if (sel) begin
        r += int'(led_red_n3 === 1'b0);
        g += int'(led_green_n3 === 1'b0);
        b += int'(led_blue_n3 === 1'b0);
      end else begin
        r += int'(led_red_n === 1'b0);
        g += int'(led_green_n === 1'b0);
        b += int'(led_blue_n === 1'b0);
      end
    end
  endtask

  task automatic send(input int r, input int g, input int b);
    duty_red   = W'(r);
    duty_green = W'(g);
    duty_blue  = W'(b);
    duty_valid = 1'b1;
  endtask

  task automatic send3(input int r, input int g, input int b);
    duty_red3   = W'(r);
    duty_green3 = W'(g);
    duty_blue3  = W'(b);
    duty_valid3 = 1'b1;
  endtask

  initial begin
    int   n, r, g, b;
    logic rdy1;

    reset = 1'b1; enable = 1'b1; duty_valid = 1'b0;
    duty_red = '0; duty_green = '0; duty_blue = '0;
    reset3 = 1'b1; enable3 = 1'b1; duty_valid3 = 1'b0;
    duty_red3 = '0; duty_green3 = '0; duty_blue3 = '0;

    // Reset state
    repeat (3) tick();
    expect_val("rst_leds", 7);  check({led_red_n, led_green_n, led_blue_n});
    expect_val("rst_ready", 1); check(duty_ready);
    expect_val("rst_ps", 0);    check(period_start);
    expect_val("rst3_leds", 7); check({led_red_n3, led_green_n3, led_blue_n3});

    // Release: pulse one cycle later, then every 15 cycles
    reset = 1'b0;
    tick();
    expect_val("ps_after_release", 1); check(period_start);
    expect_val("period_len_a", 15); wait_ps(1'b0, 40, n); check(n);
    expect_val("period_len_b", 15); wait_ps(1'b0, 40, n); check(n);

    // R=5 G=0 B=15, applied at the next boundary
    send(5, 0, 15);
    expect_val("ready_after_accept", 0);
    tick();
    duty_valid = 1'b0;
    check(duty_ready);
    expect_val("boundary_wait", 14); wait_ps(1'b0, 40, n); check(n);
    expect_val("ready_after_load", 1); check(duty_ready);
    expect_val("red_5", eff(5));
    expect_val("green_0", eff(0));
    expect_val("blue_15", eff(15));
    measure(1'b0, 15, r, g, b, rdy1);
    check(r); check(g); check(b);
    expect_val("ps_after_measure", 1); check(period_start);

    // Back-to-back triples with duty_valid held high
    send(3, 7, 1);
    expect_val("ready_first_taken", 0);
    tick();
    check(duty_ready);
    send(9, 2, 12);
    expect_val("b2b_wait", 14); wait_ps(1'b0, 40, n); check(n);
    expect_val("ready_rises_at_boundary", 1); check(duty_ready);
    expect_val("second_taken", 0);
    expect_val("red_a", eff(3));
    expect_val("green_a", eff(7));
    expect_val("blue_a", eff(1));
    measure(1'b0, 15, r, g, b, rdy1);
    check(rdy1); check(r); check(g); check(b);
    expect_val("ps_a_end", 1); check(period_start);
    expect_val("red_b", eff(9));
    expect_val("green_b", eff(2));
    expect_val("blue_b", eff(12));
    measure(1'b0, 15, r, g, b, rdy1);
    check(r); check(g); check(b);
    expect_val("ready_after_b", 1); check(duty_ready);

    // enable drop mid-period flushes the pending R=10 triple
    send(10, 4, 15);
    expect_val("ready_pend_10", 0);
    tick();
    duty_valid = 1'b0;
    check(duty_ready);
    repeat (3) tick();
    enable = 1'b0;
    tick();
    expect_val("dis_leds", 7);  check({led_red_n, led_green_n, led_blue_n});
    expect_val("dis_ready", 1); check(duty_ready);
    expect_val("dis_ps", 0);    check(period_start);
    repeat (2) tick();
    expect_val("dis_leds_hold", 7); check({led_red_n, led_green_n, led_blue_n});
    expect_val("dis_ps_hold", 0);   check(period_start);
    enable = 1'b1;
    tick();
    expect_val("ps_on_enable", 1); check(period_start);
    expect_val("red_10", eff(10));
    expect_val("green_4", eff(4));
    expect_val("blue_15b", eff(15));
    measure(1'b0, 15, r, g, b, rdy1);
    check(r); check(g); check(b);

    // Gamma corner values (identity in the default build)
    send(8, 15, 1);
    tick();
    duty_valid = 1'b0;
    expect_val("gamma_wait", 14); wait_ps(1'b0, 40, n); check(n);
    expect_val("red_8", eff(8));
    expect_val("green_15", eff(15));
    expect_val("blue_1", eff(1));
    measure(1'b0, 15, r, g, b, rdy1);
    check(r); check(g); check(b);

    // PRESCALE=3: 45-clock period, R=2 lit for 6 clocks
    reset3 = 1'b0;
    tick();
    expect_val("ps3_after_release", 1); check(period_start3);
    send3(2, 0, 0);
    tick();
    duty_valid3 = 1'b0;
    expect_val("ps3_wait", 44); wait_ps(1'b1, 100, n); check(n);
    expect_val("red3_2", 3 * eff(2));
    expect_val("green3_0", 0);
    measure(1'b1, 45, r, g, b, rdy1);
    check(r); check(g);
    expect_val("ps3_period_45", 1); check(period_start3);

    // Mid-period reset discards a pending triple
    send3(3, 3, 3);
    expect_val("ready3_pend", 0);
    expect_val("red3_lit", (eff(2) > 0) ? 0 : 1);
    tick();
    duty_valid3 = 1'b0;
    check(duty_ready3);
    check(led_red_n3);
    reset3 = 1'b1;
    tick();
    expect_val("rst3_mid_leds", 7);  check({led_red_n3, led_green_n3, led_blue_n3});
    expect_val("rst3_mid_ready", 1); check(duty_ready3);
    expect_val("rst3_mid_ps", 0);    check(period_start3);
    reset3 = 1'b0;
    tick();
    expect_val("ps3_restart", 1); check(period_start3);
    expect_val("ps3_full_period", 45); wait_ps(1'b1, 100, n); check(n);
    expect_val("red3_discarded", 0);
    measure(1'b1, 45, r, g, b, rdy1);
    check(r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
